// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU blocks: datapath byte width,
// FSM state codes and the counter-width helper.
package alu_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter width for n byte-cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder.sv
// 8-bit ripple-carry adder with carry-out and signed-overflow flags.
module adder
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              ci_i,
  output logic [BYTE_W-1:0] y_o,
  output logic              c_o,
  output logic              v_o
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    y_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < BYTE_W; i++) begin
      y_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = c[BYTE_W];
  // Overflow when carry into the sign bit differs from carry out of it.
  assign v_o = c[BYTE_W] ^ c[BYTE_W-1];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision add/subtract: streams operands LSB-first through
// one 8-bit adder, chaining the carry in a register, then presents the wide result.
module multibyte_add_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     sub_i,
  input  logic [BYTE_W*NBYTES-1:0] op_a_i,
  input  logic [BYTE_W*NBYTES-1:0] op_b_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [BYTE_W*NBYTES-1:0] result_o,
  output logic                     carry_out_o,
  output logic                     overflow_o,
  output logic                     zero_o
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned CntW = cnt_width(NBYTES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    part_q, part_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [BYTE_W-1:0]   sum_y;
  logic                sum_c;
  logic                sum_v;
  logic [W+BYTE_W-1:0] part_cat;
  logic [W-1:0]        part_nxt;

  adder u_adder (
    .a_i  (a_sh_q[BYTE_W-1:0]),
    .b_i  (b_sh_q[BYTE_W-1:0]),
    .ci_i (carry_q),
    .y_o  (sum_y),
    .c_o  (sum_c),
    .v_o  (sum_v)
  );

  // New byte enters at the top so after NBYTES shifts byte 0 sits at the bottom.
  assign part_cat = {sum_y, part_q};
  assign part_nxt = part_cat[W+BYTE_W-1:BYTE_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    part_d   = part_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_sh_d  = op_a_i;
          b_sh_d  = sub_i ? ~op_b_i : op_b_i;
          carry_d = sub_i;
          cnt_d   = '0;
          part_d  = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> BYTE_W;
        b_sh_d  = b_sh_q >> BYTE_W;
        part_d  = part_nxt;
        carry_d = sum_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = DONE;
          result_d = part_nxt;
          cout_d   = sum_c;
          ovf_d    = sum_v;
          zero_d   = (part_nxt == '0);
          done_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      part_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      part_q   <= part_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: directed vectors, control corner
// cases, an NBYTES=1 instance and randomized operations against a wide-arithmetic model.
module tb_multibyte_add_seq;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  logic        start1;
  logic        sub1;
  logic [7:0]  op_a1;
  logic [7:0]  op_b1;
  logic        busy1;
  logic        done1;
  logic [7:0]  result1;
  logic        carry_out1;
  logic        overflow1;
  logic        zero1;

  int checks = 0;
  int errors = 0;

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .sub_i       (sub),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .carry_out_o (carry_out),
    .overflow_o  (overflow),
    .zero_o      (zero)
  );

  multibyte_add_seq #(.NBYTES(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start1),
    .sub_i       (sub1),
    .op_a_i      (op_a1),
    .op_b_i      (op_b1),
    .busy_o      (busy1),
    .done_o      (done1),
    .result_o    (result1),
    .carry_out_o (carry_out1),
    .overflow_o  (overflow1),
    .zero_o      (zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: true wide arithmetic, V from operand/result signs.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic z);
    logic [32:0] t;
    if (s) t = {1'b0, a} - {1'b0, b};
    else   t = {1'b0, a} + {1'b0, b};
    r = t[31:0];
    c = s ? (a >= b) : t[32];
    if (s) v = (a[31] != b[31]) && (r[31] != a[31]);
    else   v = (a[31] == b[31]) && (r[31] != a[31]);
    z = (r == 32'd0);
  endfunction

  task automatic run4(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] er, input logic ec,
                      input logic ev, input logic ez);
    logic [31:0] prev;
    int          k;
    bit          seen;
    bit          held;
    prev = result;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    sub   = 1'($urandom);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    held = 1'b1;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1'b1;
      else if (result !== prev) held = 1'b0;
    end
    chk({nm, " latency"}, 64'(k), 64'd4);
    chk({nm, " held"}, 64'(held), 64'd1);
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " cvz"}, 64'({carry_out, overflow, zero}), 64'({ec, ev, ez}));
    @(posedge clk);
    #1;
    chk({nm, " end"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] mr;
    logic        mc;
    logic        mv;
    logic        mz;
    int          ndone;
    logic [31:0] got;

    vecs[0] = '{"carry_thru", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"full_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    op_a   = '0;
    op_b   = '0;
    start1 = 1'b0;
    sub1   = 1'b0;
    op_a1  = '0;
    op_b1  = '0;
    #12;
    chk("reset outs", 64'({result, carry_out, overflow, zero, done, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run4(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].v,
           vecs[i].z);
    end

    // start pulsed during RUN must be ignored entirely.
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'h1111_1111;
    op_b  = 32'h2222_2222;
    sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'hAAAA_AAAA;
    op_b  = 32'h0000_0001;
    sub   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    got   = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        got = result;
      end
    end
    chk("ignore_start ndone", 64'(ndone), 64'd1);
    chk("ignore_start result", 64'(got), 64'h3333_3333);

    // Reset in the second RUN cycle: outputs clear at once, no done afterwards.
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'h1234_5678;
    op_b  = 32'h0000_0001;
    sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst outs", 64'({result, carry_out, overflow, zero, done, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("async_rst quiet", 64'(ndone), 64'd0);
    run4("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // NBYTES = 1 instance.
    @(negedge clk);
    start1 = 1'b1;
    op_a1  = 8'h80;
    op_b1  = 8'h80;
    sub1   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("n1 busy", 64'({busy1, done1}), 64'b10);
    @(posedge clk);
    #1;
    chk("n1 done", 64'(done1), 64'd1);
    chk("n1 result", 64'({result1, carry_out1, overflow1, zero1}), 64'({8'h00, 3'b111}));
    @(posedge clk);
    #1;
    chk("n1 end", 64'({done1, busy1}), 64'd0);

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ra;
        2: begin
          ra = ra & 32'h0000_01FF;
          rb = rb & 32'h0000_01FF;
        end
        default: begin
          ra = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
          rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
        end
      endcase
      model(ra, rb, rs, mr, mc, mv, mz);
      run4($sformatf("rand%0d", n), ra, rb, rs, mr, mc, mv, mz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
